// File: rtl/reg_read_hazard_unit_pkg.sv
// Shared core constants: register-file geometry, load tracking depth and
// writeback-arbiter source encoding.
package reg_read_hazard_unit_pkg;

  localparam int unsigned CORE_XLEN      = 32;
  localparam int unsigned CORE_NREG      = 32;
  localparam int unsigned CORE_MAX_LOADS = 2;
  localparam int unsigned CORE_REG_AW    = $clog2(CORE_NREG);

  // Writeback arbiter sources; wb_is_mem carries the WbSrcMem encoding.
  localparam int unsigned WB_NUM_SRC = 2;
  typedef enum logic {
    WbSrcAlu = 1'b0,
    WbSrcMem = 1'b1
  } wb_src_e;

endpackage

// File: rtl/reg_read_hazard_unit_operand_bypass_mux.sv
// Per-read-port operand select: x0 reads zero, a same-cycle writeback is
// forwarded, otherwise the raw register-file data passes through.
module operand_bypass_mux
  import reg_read_hazard_unit_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN,
  parameter int unsigned AW   = CORE_REG_AW
) (
  input  logic [AW-1:0]   rs_addr_i,
  input  logic [XLEN-1:0] rf_rdata_i,
  input  logic            wb_enable_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] rs_data_o
);

  always_comb begin
    if (rs_addr_i == '0) begin
      rs_data_o = '0;
    end else if (wb_enable_i && (wb_addr_i == rs_addr_i)) begin
      rs_data_o = wb_data_i;
    end else begin
      rs_data_o = rf_rdata_i;
    end
  end

endmodule

// File: rtl/reg_read_hazard_unit.sv
// Load scoreboard, outstanding-load counter and decode stall generation,
// with per-port operand bypass.
module reg_read_hazard_unit
  import reg_read_hazard_unit_pkg::*;
#(
  parameter int unsigned XLEN      = CORE_XLEN,
  parameter int unsigned NREG      = CORE_NREG,
  parameter int unsigned MAX_LOADS = CORE_MAX_LOADS,
  localparam int unsigned AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_is_load,
  input  logic            wb_enable,
  input  logic [AW-1:0]   wb_addr,
  input  logic            wb_is_mem,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic [NREG-1:0] pending
);

  localparam int unsigned CW = $clog2(MAX_LOADS + 1);

  logic [NREG-1:0] pending_q, pending_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wb_mem, clr_hit, set_en;
  logic            rs1_blk, rs2_blk, rd_blk, cap_blk;

  always_comb begin
    wb_mem  = wb_enable & wb_is_mem;
    // A memory writeback only counts as a decrement if it retires a tracked load.
    clr_hit = wb_mem & pending_q[wb_addr];
    rs1_blk = (rs1_addr != '0) & pending_q[rs1_addr] & ~(wb_mem & (wb_addr == rs1_addr));
    rs2_blk = (rs2_addr != '0) & pending_q[rs2_addr] & ~(wb_mem & (wb_addr == rs2_addr));
    rd_blk  = (issue_rd != '0) & pending_q[issue_rd] & ~(wb_mem & (wb_addr == issue_rd));
    cap_blk = issue_is_load & (cnt_q == CW'(MAX_LOADS)) & ~clr_hit;
    stall   = issue_valid & (rs1_blk | rs2_blk | rd_blk | cap_blk);
    set_en  = issue_valid & issue_is_load & ~stall & (issue_rd != '0);
  end

  always_comb begin
    pending_d = pending_q;
    if (clr_hit) pending_d[wb_addr] = 1'b0;
    // Applied after the clear so a same-index set wins.
    if (set_en) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (set_en && !clr_hit) begin
      if (cnt_q != CW'(MAX_LOADS)) cnt_d = cnt_q + CW'(1);
    end else if (clr_hit && !set_en) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending = pending_q;

  operand_bypass_mux #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_bypass_rs1 (
    .rs_addr_i   (rs1_addr),
    .rf_rdata_i  (rf_rdata1),
    .wb_enable_i (wb_enable),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .rs_data_o   (rs1_data)
  );

  operand_bypass_mux #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_bypass_rs2 (
    .rs_addr_i   (rs2_addr),
    .rf_rdata_i  (rf_rdata2),
    .wb_enable_i (wb_enable),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .rs_data_o   (rs2_data)
  );

endmodule
